// File: rtl/axi_lite_cfg_loader_if.sv
// axi_lite_cfg_loader_if: AXI4-Lite write-channel bundle (AW, W, B) between the loader and a register slave
// Parameters: DW data width, AW address width.
// master drives awaddr/awvalid, wdata/wstrb/wvalid and bready; slave drives awready, wready, bresp and bvalid.
interface axi_lite_cfg_loader_if #(
    parameter int DW = 32,
    parameter int AW = 4
);
    logic [AW-1:0]   awaddr;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );
    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_lite_cfg_loader.sv
// axi_lite_cfg_loader: AXI4-Lite write master that replays an (address, data) table into a register slave
// Ports:
//   M_AXI_ACLK / M_AXI_ARESETN  clock, asynchronous active-low reset
//   START_I, N_ENTRIES_I        start request and entry count (sampled when START_I is accepted)
//   BUSY_O, DONE_O              sequence running, one-cycle end pulse
//   ERR_O, ERR_IDX_O            sticky error flag and index of the failing entry
//   TBL_RD_O, TBL_IDX_O         synchronous table read strobe and index
//   TBL_ADDR_I, TBL_DATA_I      table entry, valid the cycle after TBL_RD_O
//   m_axi                       AXI4-Lite write channels (master modport)
module axi_lite_cfg_loader #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 4,
    parameter int C_TBL_AW           = 4
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,
    input  logic                          START_I,
    input  logic [C_TBL_AW:0]             N_ENTRIES_I,
    output logic                          BUSY_O,
    output logic                          DONE_O,
    output logic                          ERR_O,
    output logic [C_TBL_AW-1:0]           ERR_IDX_O,
    output logic                          TBL_RD_O,
    output logic [C_TBL_AW-1:0]           TBL_IDX_O,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] TBL_ADDR_I,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] TBL_DATA_I,
    axi_lite_cfg_loader_if.master         m_axi
);
    typedef enum logic [2:0] {IDLE, RD, CAPT, XFER, RESP, FIN} state_t;

    state_t                        state_q;
    logic                          busy_q, done_q, err_q, tbl_rd_q;
    logic                          awvalid_q, wvalid_q, bready_q;
    logic [C_TBL_AW-1:0]           idx_q, err_idx_q;
    logic [C_TBL_AW:0]             n_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q;
    logic                          last, aw_done, w_done, bad_resp;

    // n_q is at least 1 whenever RESP is reachable, so n_q-1 never underflows
    assign last     = {1'b0, idx_q} == n_q - (C_TBL_AW+1)'(1);
    // a channel is finished once its valid has dropped or is being accepted this cycle
    assign aw_done  = !awvalid_q || m_axi.awready;
    assign w_done   = !wvalid_q || m_axi.wready;
    assign bad_resp = m_axi.bresp != 2'b00;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
            tbl_rd_q  <= 1'b0;
            idx_q     <= '0;
            n_q       <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (START_I) begin
                    err_q     <= 1'b0;
                    err_idx_q <= '0;
                    idx_q     <= '0;
                    n_q       <= N_ENTRIES_I;
                    busy_q    <= N_ENTRIES_I != '0;
                    tbl_rd_q  <= N_ENTRIES_I != '0;
                    state_q   <= N_ENTRIES_I != '0 ? RD : FIN;
                end
                RD: begin
                    tbl_rd_q <= 1'b0;
                    state_q  <= CAPT;
                end
                CAPT: begin
                    awaddr_q  <= TBL_ADDR_I;
                    wdata_q   <= TBL_DATA_I;
                    awvalid_q <= 1'b1;
                    wvalid_q  <= 1'b1;
                    state_q   <= XFER;
                end
                XFER: begin
                    awvalid_q <= awvalid_q && !m_axi.awready;
                    wvalid_q  <= wvalid_q && !m_axi.wready;
                    if (aw_done && w_done) begin
                        bready_q <= 1'b1;
                        state_q  <= RESP;
                    end
                end
                RESP: if (m_axi.bvalid) begin
                    bready_q <= 1'b0;
                    if (bad_resp || last) begin
                        err_q     <= bad_resp;
                        err_idx_q <= bad_resp ? idx_q : err_idx_q;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= FIN;
                    end else begin
                        idx_q    <= idx_q + C_TBL_AW'(1);
                        tbl_rd_q <= 1'b1;
                        state_q  <= RD;
                    end
                end
                // a sequence arrives here with done_q already set; the empty-sequence path
                // arrives with it clear and spends one extra cycle raising the pulse
                FIN: begin
                    done_q  <= !done_q;
                    state_q <= done_q ? IDLE : FIN;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign BUSY_O        = busy_q;
    assign DONE_O        = done_q;
    assign ERR_O         = err_q;
    assign ERR_IDX_O     = err_idx_q;
    assign TBL_RD_O      = tbl_rd_q;
    assign TBL_IDX_O     = idx_q;
    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = '1;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
endmodule

// File: tb/tb_axi_lite_cfg_loader.sv
// tb_axi_lite_cfg_loader: directed self-checking bench for axi_lite_cfg_loader with a latency-configurable slave
module tb_axi_lite_cfg_loader;
    localparam int DW  = 32;
    localparam int AW  = 4;
    localparam int TAW = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [TAW:0]   n_in = '0;
    logic           busy, done, err, tbl_rd;
    logic [TAW-1:0] err_idx, tbl_idx;
    logic [AW-1:0]  tbl_addr;
    logic [DW-1:0]  tbl_data;

    always #5 clk = ~clk;

    axi_lite_cfg_loader_if #(.DW(DW), .AW(AW)) bus ();

    axi_lite_cfg_loader #(
        .C_M_AXI_DATA_WIDTH(DW),
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_TBL_AW(TAW)
    ) dut (
        .M_AXI_ACLK(clk),
        .M_AXI_ARESETN(rst_n),
        .START_I(start),
        .N_ENTRIES_I(n_in),
        .BUSY_O(busy),
        .DONE_O(done),
        .ERR_O(err),
        .ERR_IDX_O(err_idx),
        .TBL_RD_O(tbl_rd),
        .TBL_IDX_O(tbl_idx),
        .TBL_ADDR_I(tbl_addr),
        .TBL_DATA_I(tbl_data),
        .m_axi(bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t0 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // table: entry i = (i*4 mod 16, 0x11*(i+1)); entries 0..2 are (0x0,0x11),(0x4,0x22),(0x8,0x33)
    logic [AW-1:0] t_addr [16];
    logic [DW-1:0] t_data [16];
    initial for (int i = 0; i < 16; i++) begin
        t_addr[i] = AW'(i * 4);
        t_data[i] = DW'(32'h11 * (i + 1));
    end
    always @(posedge clk) if (tbl_rd) begin
        tbl_addr <= t_addr[tbl_idx];
        tbl_data <= t_data[tbl_idx];
    end

    // slave: READY after *_lat cycles of VALID, BVALID the edge both handshakes are complete
    int            aw_lat = 1;
    int            w_lat = 1;
    int            err_at = -1;
    int            aw_wait, w_wait;
    logic          aw_got, w_got, aw_now, w_now;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_data;
    logic [AW-1:0] log_addr [64];
    logic [DW-1:0] log_data [64];
    int            wr_cnt = 0;

    assign aw_now = aw_got | (bus.awvalid & bus.awready);
    assign w_now  = w_got | (bus.wvalid & bus.wready);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.awready <= 1'b0;
            bus.wready  <= 1'b0;
            bus.bvalid  <= 1'b0;
            bus.bresp   <= 2'b00;
            aw_got      <= 1'b0;
            w_got       <= 1'b0;
            aw_wait     <= 0;
            w_wait      <= 0;
        end else begin
            if (bus.awvalid && !bus.awready) begin
                bus.awready <= aw_wait + 1 >= aw_lat;
                aw_wait     <= aw_wait + 1;
            end else begin
                bus.awready <= 1'b0;
                aw_wait     <= 0;
            end
            if (bus.wvalid && !bus.wready) begin
                bus.wready <= w_wait + 1 >= w_lat;
                w_wait     <= w_wait + 1;
            end else begin
                bus.wready <= 1'b0;
                w_wait     <= 0;
            end
            if (bus.awvalid && bus.awready) cur_addr <= bus.awaddr;
            if (bus.wvalid && bus.wready) cur_data <= bus.wdata;
            if (!bus.bvalid && aw_now && w_now) begin
                bus.bvalid <= 1'b1;
                bus.bresp  <= wr_cnt == err_at ? 2'b10 : 2'b00;
                aw_got     <= 1'b0;
                w_got      <= 1'b0;
            end else begin
                aw_got <= aw_now;
                w_got  <= w_now;
            end
            if (bus.bvalid && bus.bready) begin
                bus.bvalid <= 1'b0;
                if (wr_cnt < 64) begin
                    log_addr[wr_cnt] <= cur_addr;
                    log_data[wr_cnt] <= cur_data;
                end
                wr_cnt <= wr_cnt + 1;
            end
        end
    end

    // protocol monitor sampled on the falling edge
    int            done_cnt = 0, done_cyc = 0, rd_cnt = 0, aw_rise = 0;
    int            stab_err = 0, drop_err = 0, order_err = 0;
    logic [TAW-1:0] last_rd_idx = '0;
    logic          aw_prev = 1'b0, w_prev = 1'b0, aw_hs = 1'b0, w_hs = 1'b0, outst = 1'b0;
    logic [AW-1:0] addr_prev = '0;
    logic [DW-1:0] data_prev = '0;

    always @(negedge clk) begin
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (tbl_rd) begin
            rd_cnt      <= rd_cnt + 1;
            last_rd_idx <= tbl_idx;
        end
        if (!rst_n) begin
            aw_prev <= 1'b0;
            w_prev  <= 1'b0;
            aw_hs   <= 1'b0;
            w_hs    <= 1'b0;
            outst   <= 1'b0;
        end else begin
            if ((aw_hs && bus.awvalid) || (w_hs && bus.wvalid)) drop_err <= drop_err + 1;
            if ((aw_prev && !aw_hs && (!bus.awvalid || bus.awaddr !== addr_prev)) ||
                (w_prev && !w_hs && (!bus.wvalid || bus.wdata !== data_prev)))
                stab_err <= stab_err + 1;
            if ((bus.awvalid && !aw_prev && outst) || (bus.bready && (bus.awvalid || bus.wvalid)))
                order_err <= order_err + 1;
            if (bus.awvalid && !aw_prev) aw_rise <= aw_rise + 1;
            outst     <= (bus.awvalid && !aw_prev) || (outst && !(bus.bvalid && bus.bready));
            aw_prev   <= bus.awvalid;
            w_prev    <= bus.wvalid;
            aw_hs     <= bus.awvalid && bus.awready;
            w_hs      <= bus.wvalid && bus.wready;
            addr_prev <= bus.awaddr;
            data_prev <= bus.wdata;
        end
    end

    task automatic start_seq(input int n);
        @(posedge clk);
        #1;
        start = 1'b1;
        n_in  = n[TAW:0];
        t0    = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int limit, input string name);
        bit seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(posedge clk);
            seen = done_cnt != base;
        end
        #1;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: no DONE_O within %0d cycles", name, limit);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (err_idx !== 4'h0) begin errors++; $display("FAIL reset_err_idx: got %h want 0", err_idx); end
        checks++; if (tbl_rd !== 1'b0) begin errors++; $display("FAIL reset_tbl_rd: got %b want 0", tbl_rd); end
        checks++; if (tbl_idx !== 4'h0) begin errors++; $display("FAIL reset_tbl_idx: got %h want 0", tbl_idx); end
        checks++; if (bus.awvalid !== 1'b0) begin errors++; $display("FAIL reset_awvalid: got %b want 0", bus.awvalid); end
        checks++; if (bus.wvalid !== 1'b0) begin errors++; $display("FAIL reset_wvalid: got %b want 0", bus.wvalid); end
        checks++; if (bus.bready !== 1'b0) begin errors++; $display("FAIL reset_bready: got %b want 0", bus.bready); end
        checks++; if (bus.awaddr !== 4'h0) begin errors++; $display("FAIL reset_awaddr: got %h want 0", bus.awaddr); end
        checks++; if (bus.wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", bus.wdata); end
        checks++; if (bus.wstrb !== 4'hF) begin errors++; $display("FAIL reset_wstrb: got %h want f", bus.wstrb); end
        #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || tbl_rd !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy=%b tbl_rd=%b want 0 0", busy, tbl_rd); end
    endtask

    task automatic test_basic();
        logic [AW-1:0] ea [3] = '{4'h0, 4'h4, 4'h8};
        logic [DW-1:0] ed [3] = '{32'h11, 32'h22, 32'h33};
        int wb = wr_cnt, db = done_cnt, rb = rd_cnt;
        aw_lat = 1; w_lat = 1; err_at = -1;
        start_seq(3);
        @(negedge clk);
        checks++; if (busy !== 1'b1 || tbl_rd !== 1'b1) begin errors++; $display("FAIL basic_rd_cycle1: busy=%b tbl_rd=%b want 1 1", busy, tbl_rd); end
        wait_done(db, 40, "basic");
        checks++; if (done_cyc !== t0 + 16) begin errors++; $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc - t0, 16); end
        checks++; if (wr_cnt - wb !== 3) begin errors++; $display("FAIL basic_write_count: got %0d want 3", wr_cnt - wb); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (log_addr[wb+i] !== ea[i] || log_data[wb+i] !== ed[i]) begin
                errors++;
                $display("FAIL basic_write%0d: got (%h,%h) want (%h,%h)", i, log_addr[wb+i], log_data[wb+i], ea[i], ed[i]);
            end
        end
        checks++; if (rd_cnt - rb !== 3) begin errors++; $display("FAIL basic_reads: got %0d want 3", rd_cnt - rb); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_end_state: err=%b busy=%b want 0 0", err, busy); end
        checks++; if (done_cnt - db !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt - db); end
    endtask

    task automatic test_zero();
        int db = done_cnt, ab = aw_rise;
        start_seq(0);
        wait_done(db, 10, "zero");
        checks++; if (done_cyc !== t0 + 2) begin errors++; $display("FAIL zero_done_cycle: got %0d want 2", done_cyc - t0); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (aw_rise !== ab) begin errors++; $display("FAIL zero_no_traffic: got %0d awvalid rises want 0", aw_rise - ab); end
        checks++; if (busy !== 1'b0 || done_cnt - db !== 1) begin errors++; $display("FAIL zero_end: busy=%b pulses=%0d want 0 1", busy, done_cnt - db); end
    endtask

    task automatic run_skew(input int al, input int wl, input int exp_cyc, input string name);
        int wb = wr_cnt, db = done_cnt;
        aw_lat = al; w_lat = wl; err_at = -1;
        start_seq(2);
        wait_done(db, 60, name);
        checks++; if (done_cyc !== t0 + exp_cyc) begin errors++; $display("FAIL %s_done_cycle: got %0d want %0d", name, done_cyc - t0, exp_cyc); end
        checks++;
        if (wr_cnt - wb !== 2 || log_addr[wb+1] !== 4'h4 || log_data[wb+1] !== 32'h22) begin
            errors++;
            $display("FAIL %s_writes: count %0d last (%h,%h) want 2 (4,00000022)", name, wr_cnt - wb, log_addr[wb+1], log_data[wb+1]);
        end
    endtask

    task automatic test_skew();
        run_skew(4, 1, 17, "w_first");
        run_skew(1, 4, 17, "aw_first");
        run_skew(2, 2, 13, "same_cycle");
        checks++; if (stab_err !== 0) begin errors++; $display("FAIL skew_stability: got %0d violations want 0", stab_err); end
        checks++; if (drop_err !== 0) begin errors++; $display("FAIL skew_valid_drop: got %0d violations want 0", drop_err); end
        checks++; if (order_err !== 0) begin errors++; $display("FAIL skew_ordering: got %0d violations want 0", order_err); end
        aw_lat = 1; w_lat = 1;
    endtask

    task automatic test_error();
        int wb = wr_cnt, db = done_cnt, rb = rd_cnt;
        err_at = wr_cnt + 1;
        start_seq(4);
        wait_done(db, 60, "error");
        checks++; if (done_cyc !== t0 + 11) begin errors++; $display("FAIL error_done_cycle: got %0d want 11", done_cyc - t0); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL error_flag: got %b want 1", err); end
        checks++; if (err_idx !== 4'h1) begin errors++; $display("FAIL error_idx: got %h want 1", err_idx); end
        checks++; if (wr_cnt - wb !== 2 || rd_cnt - rb !== 2) begin errors++; $display("FAIL error_skip: writes=%0d reads=%0d want 2 2", wr_cnt - wb, rd_cnt - rb); end
        err_at = -1;
        db = done_cnt;
        start_seq(1);
        @(negedge clk);
        checks++; if (err !== 1'b0 || err_idx !== 4'h0) begin errors++; $display("FAIL error_clear: err=%b idx=%h want 0 0", err, err_idx); end
        wait_done(db, 20, "error_restart");
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL error_restart_flag: got %b want 0", err); end
    endtask

    task automatic test_reset_mid();
        int db, wb, rb;
        bit seen = 0;
        start_seq(3);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.awvalid;
        end
        checks++; if (!seen) begin errors++; $display("FAIL rstmid_awvalid_timeout: awvalid=%b want 1", bus.awvalid); end
        db = done_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.awvalid !== 1'b0 || bus.wvalid !== 1'b0 || bus.bready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: aw=%b w=%b b=%b busy=%b want 0 0 0 0", bus.awvalid, bus.wvalid, bus.bready, busy);
        end
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (done_cnt !== db) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_cnt - db); end
        wb = wr_cnt; rb = rd_cnt;
        start_seq(1);
        wait_done(db, 20, "rstmid_restart");
        checks++; if (done_cyc !== t0 + 6) begin errors++; $display("FAIL rstmid_done_cycle: got %0d want 6", done_cyc - t0); end
        checks++;
        if (wr_cnt - wb !== 1 || rd_cnt - rb !== 1 || last_rd_idx !== 4'h0 || log_addr[wb] !== 4'h0 || log_data[wb] !== 32'h11) begin
            errors++;
            $display("FAIL rstmid_restart_idx0: writes=%0d rd_idx=%h entry (%h,%h) want 1 0 (0,00000011)", wr_cnt - wb, last_rd_idx, log_addr[wb], log_data[wb]);
        end
    endtask

    task automatic test_busy_ignore();
        int wb = wr_cnt, db = done_cnt;
        start_seq(3);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        n_in  = 5'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(db, 40, "busy_ignore");
        checks++; if (done_cyc !== t0 + 16) begin errors++; $display("FAIL busy_ignore_done_cycle: got %0d want 16", done_cyc - t0); end
        checks++; if (wr_cnt - wb !== 3) begin errors++; $display("FAIL busy_ignore_writes: got %0d want 3", wr_cnt - wb); end
        repeat (4) @(posedge clk);
        #1;
        checks++; if (done_cnt - db !== 1 || busy !== 1'b0) begin errors++; $display("FAIL busy_ignore_end: pulses=%0d busy=%b want 1 0", done_cnt - db, busy); end
    endtask

    task automatic test_full_table();
        int wb = wr_cnt, db = done_cnt, rb = rd_cnt;
        start_seq(16);
        wait_done(db, 120, "full");
        checks++; if (done_cyc !== t0 + 81) begin errors++; $display("FAIL full_done_cycle: got %0d want 81", done_cyc - t0); end
        checks++; if (wr_cnt - wb !== 16 || rd_cnt - rb !== 16 || last_rd_idx !== 4'hF) begin errors++; $display("FAIL full_count: writes=%0d reads=%0d last_idx=%h want 16 16 f", wr_cnt - wb, rd_cnt - rb, last_rd_idx); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (log_addr[wb+i] !== t_addr[i] || log_data[wb+i] !== t_data[i]) begin
                errors++;
                $display("FAIL full_write%0d: got (%h,%h) want (%h,%h)", i, log_addr[wb+i], log_data[wb+i], t_addr[i], t_data[i]);
            end
        end
        checks++; if (stab_err + drop_err + order_err !== 0) begin errors++; $display("FAIL protocol_total: got %0d violations want 0", stab_err + drop_err + order_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_skew();
        test_error();
        test_reset_mid();
        test_busy_ignore();
        test_full_table();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/axi_lite_cfg_loader.md
Name: axi_lite_cfg_loader

Overview:
AXI4-Lite write-only master that sequences a table of (address, data) pairs into an AXI4-Lite slave register block at bring-up or on request.
- Fetches one entry at a time from a synchronous-read table (ROM/BRAM) and issues one complete write transaction per entry.
- Stops on the first error response.
- Sits between the system control logic (START/DONE) and any AXI4-Lite slave register interface.

Parameters:
C_M_AXI_DATA_WIDTH, 32, AXI data width; also the table data width.
C_M_AXI_ADDR_WIDTH, 4, AXI address width; also the table address-field width.
C_TBL_AW, 4, table index width; table depth is 2**C_TBL_AW.

Ports:
M_AXI_ACLK  in  1  clock
M_AXI_ARESETN  in  1  reset, asynchronous, active-low
START_I  in  1  one-cycle start request
N_ENTRIES_I  in  C_TBL_AW+1  number of entries to load (0..2**C_TBL_AW), sampled on accepted START_I
BUSY_O  out  1  high while a sequence runs
DONE_O  out  1  one-cycle pulse at sequence end (success or error)
ERR_O  out  1  sticky error flag, cleared on next accepted START_I
ERR_IDX_O  out  C_TBL_AW  index of the failing entry; valid while ERR_O=1
TBL_RD_O  out  1  table read strobe
TBL_IDX_O  out  C_TBL_AW  table read index
TBL_ADDR_I  in  C_M_AXI_ADDR_WIDTH  entry address; valid the cycle after TBL_RD_O
TBL_DATA_I  in  C_M_AXI_DATA_WIDTH  entry data; valid the cycle after TBL_RD_O
M_AXI_AWADDR  out  C_M_AXI_ADDR_WIDTH  write address
M_AXI_AWVALID  out  1
M_AXI_AWREADY  in  1
M_AXI_WDATA  out  C_M_AXI_DATA_WIDTH  write data
M_AXI_WSTRB  out  C_M_AXI_DATA_WIDTH/8  constant all ones
M_AXI_WVALID  out  1
M_AXI_WREADY  in  1
M_AXI_BRESP  in  2  write response
M_AXI_BVALID  in  1
M_AXI_BREADY  out  1

Behaviour:
- Clock and reset: single clock M_AXI_ACLK; M_AXI_ARESETN is asynchronous, active-low.
- All outputs are registered.
- Reset values: BUSY_O=0, DONE_O=0, ERR_O=0, ERR_IDX_O=0, TBL_RD_O=0, TBL_IDX_O=0, AWVALID=0, WVALID=0, BREADY=0, AWADDR=0, WDATA=0; FSM in IDLE.
- Reset mid-sequence: all valids drop immediately and the sequence is abandoned; no DONE_O pulse.
- FSM states: IDLE, RD, CAPT, XFER, RESP, FIN.
- IDLE:
  - START_I=1 with N_ENTRIES_I>0: latch N, clear ERR_O/ERR_IDX_O, idx=0, BUSY_O=1, go to RD.
  - START_I=1 with N_ENTRIES_I=0: clear ERR_O and go to FIN; no AXI traffic.
  - START_I while not in IDLE is ignored.
- RD: TBL_RD_O=1 for exactly one cycle with TBL_IDX_O=idx; go to CAPT.
- CAPT: register TBL_ADDR_I into AWADDR and TBL_DATA_I into WDATA; set AWVALID=1 and WVALID=1; go to XFER.
- XFER:
  - AWVALID drops on the cycle after AWVALID&AWREADY; WVALID drops on the cycle after WVALID&WREADY.
  - The two handshakes are independent: either order, or the same cycle.
  - AWADDR and WDATA stay stable while their valid is high.
  - Once both handshakes are complete, go to RESP.
- RESP:
  - BREADY=1; BREADY is high only in RESP.
  - On BVALID=1 with BRESP=2'b00: BREADY drops; if idx==N-1 go to FIN, else idx++ and go to RD.
  - On BVALID=1 with BRESP!=2'b00: ERR_O=1, ERR_IDX_O=idx, go to FIN; remaining entries are skipped.
- FIN: DONE_O=1 for one cycle, BUSY_O=0, go to IDLE.
- Strict one-outstanding-transaction rule: the next AWVALID never rises before the previous BVALID handshake.
- Throughput against a slave that asserts AWREADY/WREADY one cycle after VALID and BVALID one cycle after the W handshake:
  - START at cycle 0: RD@1, CAPT@2, AWVALID/WVALID high @3–4, RESP@5, B handshake @5.
  - Each entry costs 5 cycles; N entries give DONE_O at cycle 5N+1.
- Idx arithmetic: idx never wraps. N=2**C_TBL_AW loads indices 0..2**C_TBL_AW-1 and then stops.

Test Plan:
- Reset, then START_I with N=3, table {(0x0,0x11),(0x4,0x22),(0x8,0x33)}, slave with 1-cycle READY/BVALID latency → exactly 3 writes in table order, BRESP OKAY, DONE_O pulse at cycle 16, ERR_O=0.
- N=0 → no AWVALID, DONE_O pulse 2 cycles after START_I, BUSY_O low afterwards.
- Slave asserts WREADY 3 cycles before AWREADY, and in a second run both in the same cycle → AWADDR/WDATA stable while valid; each valid drops one cycle after its handshake; RESP entered only after both handshakes; BREADY high only after both.
- Slave returns BRESP=2'b10 on entry 1 of N=4 → ERR_O=1, ERR_IDX_O=1, entries 2–3 never issued, DONE_O pulses; next START_I clears ERR_O.
- Assert M_AXI_ARESETN=0 asynchronously mid-XFER → AWVALID/WVALID/BREADY/BUSY_O go to 0 without waiting for a clock edge; no DONE_O; after release a new START_I restarts from idx 0.
- START_I pulsed while BUSY_O=1 → ignored; N_ENTRIES_I changed mid-run has no effect; sequence completes with the originally latched N.
